// File: rtl/rope_table_gen_pkg.sv
// Shared constants, state encoding and the quarter-wave sine table for the
// RoPE sin/cos table generator.
package rope_table_gen_pkg;

  localparam int ROPE_PHASE_W   = 24;
  localparam int ROPE_LUT_DEPTH = 64;
  localparam int DATA_W         = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_COS    = 3'd1,
    S_WR_SIN    = 3'd2,
    S_NEXT_PAIR = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  // round(127*sin(2*pi*k/256)) for k = 0..63; entry 64 is the peak, handled by the caller
  function automatic logic [6:0] rope_quarter_mag(input logic [5:0] i_k);
    logic [6:0] w_m;
    case (i_k)
      6'd0:  w_m = 7'd0;   6'd1:  w_m = 7'd3;   6'd2:  w_m = 7'd6;   6'd3:  w_m = 7'd9;
      6'd4:  w_m = 7'd12;  6'd5:  w_m = 7'd16;  6'd6:  w_m = 7'd19;  6'd7:  w_m = 7'd22;
      6'd8:  w_m = 7'd25;  6'd9:  w_m = 7'd28;  6'd10: w_m = 7'd31;  6'd11: w_m = 7'd34;
      6'd12: w_m = 7'd37;  6'd13: w_m = 7'd40;  6'd14: w_m = 7'd43;  6'd15: w_m = 7'd46;
      6'd16: w_m = 7'd49;  6'd17: w_m = 7'd51;  6'd18: w_m = 7'd54;  6'd19: w_m = 7'd57;
      6'd20: w_m = 7'd60;  6'd21: w_m = 7'd63;  6'd22: w_m = 7'd65;  6'd23: w_m = 7'd68;
      6'd24: w_m = 7'd71;  6'd25: w_m = 7'd73;  6'd26: w_m = 7'd76;  6'd27: w_m = 7'd78;
      6'd28: w_m = 7'd81;  6'd29: w_m = 7'd83;  6'd30: w_m = 7'd85;  6'd31: w_m = 7'd88;
      6'd32: w_m = 7'd90;  6'd33: w_m = 7'd92;  6'd34: w_m = 7'd94;  6'd35: w_m = 7'd96;
      6'd36: w_m = 7'd98;  6'd37: w_m = 7'd100; 6'd38: w_m = 7'd102; 6'd39: w_m = 7'd104;
      6'd40: w_m = 7'd106; 6'd41: w_m = 7'd107; 6'd42: w_m = 7'd109; 6'd43: w_m = 7'd111;
      6'd44: w_m = 7'd112; 6'd45: w_m = 7'd113; 6'd46: w_m = 7'd115; 6'd47: w_m = 7'd116;
      6'd48: w_m = 7'd117; 6'd49: w_m = 7'd118; 6'd50: w_m = 7'd120; 6'd51: w_m = 7'd121;
      6'd52: w_m = 7'd122; 6'd53: w_m = 7'd122; 6'd54: w_m = 7'd123; 6'd55: w_m = 7'd124;
      6'd56: w_m = 7'd125; 6'd57: w_m = 7'd125; 6'd58: w_m = 7'd126; 6'd59: w_m = 7'd126;
      6'd60: w_m = 7'd126; 6'd61: w_m = 7'd127; 6'd62: w_m = 7'd127; 6'd63: w_m = 7'd127;
      default: w_m = 7'd0;
    endcase
    return w_m;
  endfunction

endpackage

// File: rtl/rope_table_gen_if.sv
// Command, SRAM1 write port and status bundle of the RoPE table generator;
// master = NPU controller side, slave = the generator.
interface rope_table_gen_if #(
  parameter int PHASE_W = 24
);
  import rope_table_gen_pkg::*;

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [15:0]              num_pos;
  logic [15:0]              head_dim;
  logic [15:0]              sin_base;
  logic [15:0]              cos_base;
  logic [PHASE_W-1:0]       step0;
  logic [15:0]              ratio;
  logic                     sram_wr_en;
  logic [15:0]              sram_wr_addr;
  logic [DATA_W-1:0]        sram_wr_data;
  logic                     busy;
  logic                     done;

  modport master (
    output cmd_valid, num_pos, head_dim, sin_base, cos_base, step0, ratio,
    input  cmd_ready, sram_wr_en, sram_wr_addr, sram_wr_data, busy, done
  );

  modport slave (
    input  cmd_valid, num_pos, head_dim, sin_base, cos_base, step0, ratio,
    output cmd_ready, sram_wr_en, sram_wr_addr, sram_wr_data, busy, done
  );

endinterface

// File: rtl/rope_table_gen_sin_lut.sv
// Combinational signed Q1.7 sine lookup over a 256-step turn, folded onto the
// quarter-wave table held in the package.
module rope_sin_lut
  import rope_table_gen_pkg::*;
(
  input  logic [7:0]               i_idx,
  output logic signed [DATA_W-1:0] o_val
);

  logic [1:0] w_quad;
  logic [5:0] w_off;
  logic [6:0] w_fold;
  logic [6:0] w_mag;

  // Mirror odd quadrants, negate the lower half-turn; the folded index 64 is the peak
  always_comb begin
    w_quad = i_idx[7:6];
    w_off  = i_idx[5:0];
    if (w_quad[0]) begin
      w_fold = 7'(ROPE_LUT_DEPTH) - {1'b0, w_off};
    end else begin
      w_fold = {1'b0, w_off};
    end
    if (w_fold == 7'(ROPE_LUT_DEPTH)) begin
      w_mag = 7'd127;
    end else begin
      w_mag = rope_quarter_mag(w_fold[5:0]);
    end
    if (w_quad[1]) begin
      o_val = -$signed({1'b0, w_mag});
    end else begin
      o_val = $signed({1'b0, w_mag});
    end
  end

endmodule

// File: rtl/rope_table_gen.sv
// RoPE sin/cos table generator: fills cos[pos,pair] and sin[pos,pair] into SRAM1.
// Optional ROPE_TABLE_ABORT_EN adds an abort input that ends the run early.
module rope_table_gen
  import rope_table_gen_pkg::*;
#(
  parameter int PHASE_W = ROPE_PHASE_W
) (
  input  logic clk,
  input  logic rst_n,
`ifdef ROPE_TABLE_ABORT_EN
  input  logic abort,
`endif
  rope_table_gen_if.slave bus
);

  localparam int PROD_W = PHASE_W + 16;

  state_t             r_state;
  logic [15:0]        r_num_pos;
  logic [15:0]        r_half_dim;
  logic [15:0]        r_sin_base;
  logic [15:0]        r_cos_base;
  logic [15:0]        r_ratio;
  logic [15:0]        r_pos;
  logic [15:0]        r_pair;
  logic [15:0]        r_off;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] r_step;

  logic [15:0]              w_half_dim;
  logic [PROD_W-1:0]        w_prod;
  logic [PHASE_W-1:0]       w_step_next;
  logic [PHASE_W-1:0]       w_phase_rnd;
  logic [7:0]               w_sin_idx;
  logic [7:0]               w_cos_idx;
  logic signed [DATA_W-1:0] w_sin_val;
  logic signed [DATA_W-1:0] w_cos_val;
  logic                     w_last_pos;
  logic                     w_last_pair;
  logic                     w_abort;

`ifdef ROPE_TABLE_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_half_dim  = bus.head_dim >> 1;
  assign w_prod      = PROD_W'(r_step) * PROD_W'(r_ratio);
  assign w_step_next = PHASE_W'(w_prod >> 16);
  // Add half an index step so the 8-bit index is the nearest, not the floor
  assign w_phase_rnd = r_phase + (PHASE_W'(1) << (PHASE_W - 9));
  assign w_sin_idx   = 8'(w_phase_rnd >> (PHASE_W - 8));
  assign w_cos_idx   = w_sin_idx + 8'd64;
  assign w_last_pos  = (r_pos == (r_num_pos - 16'd1));
  assign w_last_pair = (r_pair == (r_half_dim - 16'd1));

  rope_sin_lut u_sin_lut (
    .i_idx (w_sin_idx),
    .o_val (w_sin_val)
  );

  rope_sin_lut u_cos_lut (
    .i_idx (w_cos_idx),
    .o_val (w_cos_val)
  );

  // Command capture, pair-outer/pos-inner sweep and phase/step update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_num_pos  <= 16'd0;
      r_half_dim <= 16'd0;
      r_sin_base <= 16'd0;
      r_cos_base <= 16'd0;
      r_ratio    <= 16'd0;
      r_pos      <= 16'd0;
      r_pair     <= 16'd0;
      r_off      <= 16'd0;
      r_phase    <= '0;
      r_step     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_num_pos  <= bus.num_pos;
            r_half_dim <= w_half_dim;
            r_sin_base <= bus.sin_base;
            r_cos_base <= bus.cos_base;
            r_ratio    <= bus.ratio;
            r_pos      <= 16'd0;
            r_pair     <= 16'd0;
            r_off      <= 16'd0;
            r_phase    <= '0;
            r_step     <= bus.step0;
            if ((bus.num_pos == 16'd0) || (w_half_dim == 16'd0)) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_WR_COS;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WR_COS: begin
          if (w_abort) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_WR_SIN;
          end
        end
        S_WR_SIN: begin
          if (w_abort) begin
            r_state <= S_DONE;
          end else if (w_last_pos && w_last_pair) begin
            r_state <= S_DONE;
          end else if (w_last_pos) begin
            r_state <= S_NEXT_PAIR;
          end else begin
            r_pos   <= r_pos + 16'd1;
            r_phase <= r_phase + r_step;
            r_off   <= r_off + r_half_dim;
            r_state <= S_WR_COS;
          end
        end
        S_NEXT_PAIR: begin
          if (w_abort) begin
            r_state <= S_DONE;
          end else begin
            r_step  <= w_step_next;
            r_phase <= '0;
            r_pos   <= 16'd0;
            r_pair  <= r_pair + 16'd1;
            r_off   <= r_pair + 16'd1;
            r_state <= S_WR_COS;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Write port is decoded from the registered state so reset clears it at once
  always_comb begin
    bus.sram_wr_en   = 1'b0;
    bus.sram_wr_addr = 16'd0;
    bus.sram_wr_data = '0;
    case (r_state)
      S_WR_COS: begin
        bus.sram_wr_en   = 1'b1;
        bus.sram_wr_addr = r_cos_base + r_off;
        bus.sram_wr_data = w_cos_val;
      end
      S_WR_SIN: begin
        bus.sram_wr_en   = 1'b1;
        bus.sram_wr_addr = r_sin_base + r_off;
        bus.sram_wr_data = w_sin_val;
      end
      default: begin
        bus.sram_wr_en   = 1'b0;
        bus.sram_wr_addr = 16'd0;
        bus.sram_wr_data = '0;
      end
    endcase
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);

endmodule

// File: tb/tb_rope_table_gen.sv
// Directed, table-driven bench for rope_table_gen: command vectors with
// hand-computed write streams plus reset, busy-ignore and abort sequences.
module tb_rope_table_gen;
  import rope_table_gen_pkg::*;

  typedef struct {
    logic [15:0]       addr;
    logic signed [7:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] num_pos;
    logic [15:0] head_dim;
    logic [15:0] sin_base;
    logic [15:0] cos_base;
    logic [23:0] step0;
    logic [15:0] ratio;
    int          exp_cycles;
    int          wr_first;
    int          wr_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef ROPE_TABLE_ABORT_EN
  logic abort = 1'b0;
`endif

  rope_table_gen_if bus ();

  rope_table_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef ROPE_TABLE_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_vec  = 0;
  int   n_fail = 0;
  wr_t  exp_wr[$];
  wr_t  got_wr[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic [15:0] np, input logic [15:0] hd, input logic [15:0] sb,
                         input logic [15:0] cb, input logic [23:0] st, input logic [15:0] ra,
                         input int cyc);
    vec_t v;
    v.num_pos = np; v.head_dim = hd; v.sin_base = sb; v.cos_base = cb;
    v.step0 = st; v.ratio = ra; v.exp_cycles = cyc;
    v.wr_first = exp_wr.size(); v.wr_cnt = 0;
    vecs.push_back(v);
  endtask

  task automatic add_wr(input logic [15:0] a, input int d);
    wr_t w;
    w.addr = a;
    w.data = 8'(d);
    exp_wr.push_back(w);
    vecs[vecs.size()-1].wr_cnt++;
  endtask

  task automatic start_cmd(input vec_t v);
    @(negedge clk);
    chk("ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.num_pos  = v.num_pos;
    bus.head_dim = v.head_dim;
    bus.sin_base = v.sin_base;
    bus.cos_base = v.cos_base;
    bus.step0    = v.step0;
    bus.ratio    = v.ratio;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic record_wr();
    wr_t w;
    if (bus.sram_wr_en) begin
      w.addr = bus.sram_wr_addr;
      w.data = $signed(bus.sram_wr_data);
      got_wr.push_back(w);
    end
  endtask

  task automatic collect(input int limit, output int n);
    bit seen;
    int bad;
    got_wr.delete();
    n = 0; seen = 1'b0; bad = 0;
    while (!seen && n < limit) begin
      @(negedge clk);
      n++;
      record_wr();
      if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) bad++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk("busy_during_run", bad, 0);
    if (!seen) begin
      n_vec++; n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", limit);
    end
  endtask

  task automatic check_writes(input vec_t v, input string tag);
    int m;
    chk({tag, "_wr_count"}, got_wr.size(), v.wr_cnt);
    m = (got_wr.size() < v.wr_cnt) ? got_wr.size() : v.wr_cnt;
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s_addr[%0d]", tag, i), 32'(got_wr[i].addr), 32'(exp_wr[v.wr_first+i].addr));
      chk($sformatf("%s_data[%0d]", tag, i), 32'(got_wr[i].data), 32'(exp_wr[v.wr_first+i].data));
    end
  endtask

  initial begin
    int n;
    bit seen;
    // v0: basic 4x4 table
    add_vec(16'd4, 16'd4, 16'h0200, 16'h0100, 24'h400000, 16'h8000, 18);
    add_wr(16'h0100, 127);  add_wr(16'h0200, 0);
    add_wr(16'h0102, 0);    add_wr(16'h0202, 127);
    add_wr(16'h0104, -127); add_wr(16'h0204, 0);
    add_wr(16'h0106, 0);    add_wr(16'h0206, -127);
    add_wr(16'h0101, 127);  add_wr(16'h0201, 0);
    add_wr(16'h0103, 90);   add_wr(16'h0203, 90);
    add_wr(16'h0105, 0);    add_wr(16'h0205, 127);
    add_wr(16'h0107, -90);  add_wr(16'h0207, 90);
    // v1/v2/v3: degenerate commands, no writes
    add_vec(16'd0, 16'd4, 16'h0200, 16'h0100, 24'h400000, 16'h8000, 1);
    add_vec(16'd4, 16'd0, 16'h0200, 16'h0100, 24'h400000, 16'h8000, 1);
    add_vec(16'd4, 16'd1, 16'h0200, 16'h0100, 24'h400000, 16'h8000, 1);
    // v4: single position, three pairs
    add_vec(16'd1, 16'd6, 16'h0400, 16'h0300, 24'h123456, 16'h8000, 9);
    add_wr(16'h0300, 127); add_wr(16'h0400, 0);
    add_wr(16'h0301, 127); add_wr(16'h0401, 0);
    add_wr(16'h0302, 127); add_wr(16'h0402, 0);
    // v5: phase wrap and cos address wrap past 0xFFFF
    add_vec(16'd6, 16'd2, 16'h0010, 16'hFFFE, 24'h600000, 16'h8000, 13);
    add_wr(16'hFFFE, 127);  add_wr(16'h0010, 0);
    add_wr(16'hFFFF, -90);  add_wr(16'h0011, 90);
    add_wr(16'h0000, 0);    add_wr(16'h0012, -127);
    add_wr(16'h0001, 90);   add_wr(16'h0013, 90);
    add_wr(16'h0002, -127); add_wr(16'h0014, 0);
    add_wr(16'h0003, 90);   add_wr(16'h0015, -90);
    // v6: ratio 0.75 gives pair-1 step 0x300000 -> index 48
    add_vec(16'd2, 16'd4, 16'h0020, 16'h0010, 24'h400000, 16'hC000, 10);
    add_wr(16'h0010, 127); add_wr(16'h0020, 0);
    add_wr(16'h0012, 0);   add_wr(16'h0022, 127);
    add_wr(16'h0011, 127); add_wr(16'h0021, 0);
    add_wr(16'h0013, 49);  add_wr(16'h0023, 117);
    // v7: half-index phase step exercises index rounding
    add_vec(16'd3, 16'd2, 16'h0050, 16'h0040, 24'h008000, 16'h8000, 7);
    add_wr(16'h0040, 127); add_wr(16'h0050, 0);
    add_wr(16'h0041, 127); add_wr(16'h0051, 3);
    add_wr(16'h0042, 127); add_wr(16'h0052, 3);

    bus.cmd_valid = 1'b0;
    bus.num_pos = 16'd0; bus.head_dim = 16'd0; bus.sin_base = 16'd0;
    bus.cos_base = 16'd0; bus.step0 = 24'd0; bus.ratio = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_wr_en", 32'(bus.sram_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(bus.sram_wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.sram_wr_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      start_cmd(vecs[k]);
      collect(200, n);
      chk($sformatf("v%0d_cycles", k), n, vecs[k].exp_cycles);
      check_writes(vecs[k], $sformatf("v%0d", k));
    end

    // Reset asserted during S_WR_SIN, then a clean rerun
    start_cmd(vecs[0]);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_wr_en", 32'(bus.sram_wr_en), 32'd1);
    chk("pre_rst_addr", 32'(bus.sram_wr_addr), 32'h0200);
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(bus.sram_wr_en), 32'd0);
    chk("midrst_addr", 32'(bus.sram_wr_addr), 32'd0);
    chk("midrst_data", 32'(bus.sram_wr_data), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    start_cmd(vecs[5]);
    collect(200, n);
    chk("postrst_cycles", n, vecs[5].exp_cycles);
    check_writes(vecs[5], "postrst");

    // New command presented while busy must not disturb the running table
    start_cmd(vecs[0]);
    got_wr.delete();
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 3) begin
        bus.sin_base  = 16'h0500;
        bus.cos_base  = 16'h0600;
        bus.cmd_valid = 1'b1;
      end
      record_wr();
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk("ignore_cycles", n, 18);
    check_writes(vecs[0], "ignore");
    @(negedge clk);
    chk("ignore_idle_ready", 32'(bus.cmd_ready), 32'd1);
    chk("ignore_idle_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    chk("b2b_wr_en", 32'(bus.sram_wr_en), 32'd1);
    chk("b2b_addr", 32'(bus.sram_wr_addr), 32'h0600);
    chk("b2b_data", 32'(bus.sram_wr_data), 32'd127);
    collect(100, n);
    chk("b2b_rest_cycles", n, 17);
    chk("b2b_rest_writes", got_wr.size(), 15);

`ifdef ROPE_TABLE_ABORT_EN
    // Abort sampled in the third busy cycle: three writes land, then done
    start_cmd(vecs[0]);
    got_wr.delete();
    n = 0; seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      record_wr();
      abort = (n == 3);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    abort = 1'b0;
    chk("abort_writes", got_wr.size(), 3);
    chk("abort_done_cycle", n, 4);
    @(negedge clk);
    chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
